// File: rtl/cache_hit_select.sv
// cache_hit_select: N-way tag compare, hit-way block select and word extract,
// split over two registered stages with valid/ready handshakes on both sides.
// Also keeps saturating hit/miss statistics for completed responses.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer. req_ready depends only on internal state and
// rsp_ready, never on req_valid. rsp_* are held stable while rsp_valid is high
// and rsp_ready is low.
module cache_hit_select #(
   parameter int TAG           = 20,
   parameter int WAYS          = 4,
   parameter int DATA_BLOCK    = 128,
   parameter int WORD_SIZE_BIT = 32,
   parameter int CNT_W         = 32,
   localparam int WORDS  = DATA_BLOCK / WORD_SIZE_BIT,
   localparam int WORD_W = $clog2(WORDS),
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [TAG-1:0]             req_tag,
   input  logic [WORD_W-1:0]          req_word,
   input  logic [WAYS*TAG-1:0]        way_tag,
   input  logic [WAYS-1:0]            way_valid,
   input  logic [WAYS*DATA_BLOCK-1:0] way_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_hit,
   output logic [WAY_W-1:0]           rsp_way,
   output logic                       rsp_multi_hit,
   output logic [WORD_SIZE_BIT-1:0]   rsp_word,
   input  logic                       clr_stats,
   output logic [CNT_W-1:0]           hit_count,
   output logic [CNT_W-1:0]           miss_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // stage 1 registers (tag compare result and selected block)
   logic                     s1_valid_q;
   logic                     s1_hit_q,   s1_hit_d;
   logic [WAY_W-1:0]         s1_way_q,   s1_way_d;
   logic                     s1_multi_q, s1_multi_d;
   logic [DATA_BLOCK-1:0]    s1_block_q, s1_block_d;
   logic [WORD_W-1:0]        s1_word_q;

   // stage 2 registers (the response outputs)
   logic                     rsp_valid_q;
   logic                     rsp_hit_q;
   logic [WAY_W-1:0]         rsp_way_q;
   logic                     rsp_multi_q;
   logic [WORD_SIZE_BIT-1:0] rsp_word_q, rsp_word_d;

   // statistics
   logic [CNT_W-1:0]         hit_count_q,  hit_count_d;
   logic [CNT_W-1:0]         miss_count_q, miss_count_d;

   logic adv1, adv2, rsp_fire;

   // a stage may load when it is empty or its content moves on this edge
   assign adv2      = !rsp_valid_q || rsp_ready;
   assign adv1      = !s1_valid_q || adv2;
   assign req_ready = adv1;
   assign rsp_fire  = rsp_valid_q && rsp_ready;

   // valid-gated tag compare; the lowest matching way wins, further matches flag multi-hit
   always_comb begin
      s1_hit_d   = 1'b0;
      s1_way_d   = '0;
      s1_multi_d = 1'b0;
      s1_block_d = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (way_valid[i] && (way_tag[i*TAG +: TAG] == req_tag)) begin
            if (s1_hit_d) begin
               s1_multi_d = 1'b1;
            end else begin
               s1_hit_d   = 1'b1;
               s1_way_d   = WAY_W'(i);
               s1_block_d = way_data[i*DATA_BLOCK +: DATA_BLOCK];
            end
         end
      end
   end

   // addressed word out of the stage-1 block, forced to zero on a miss
   always_comb begin
      rsp_word_d = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (s1_hit_q && (WORD_W'(w) == s1_word_q)) begin
            rsp_word_d = s1_block_q[w*WORD_SIZE_BIT +: WORD_SIZE_BIT];
         end
      end
   end

   // stage 1: capture compare result when a request is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_hit_q   <= 1'b0;
         s1_way_q   <= '0;
         s1_multi_q <= 1'b0;
         s1_block_q <= '0;
         s1_word_q  <= '0;
      end else if (adv1) begin
         s1_valid_q <= req_valid;
         if (req_valid) begin
            s1_hit_q   <= s1_hit_d;
            s1_way_q   <= s1_way_d;
            s1_multi_q <= s1_multi_d;
            s1_block_q <= s1_block_d;
            s1_word_q  <= req_word;
         end
      end
   end

   // stage 2: response registers, held while the consumer stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_way_q   <= '0;
         rsp_multi_q <= 1'b0;
         rsp_word_q  <= '0;
      end else if (adv2) begin
         rsp_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            rsp_hit_q   <= s1_hit_q;
            rsp_way_q   <= s1_way_q;
            rsp_multi_q <= s1_multi_q;
            rsp_word_q  <= rsp_word_d;
         end
      end
   end

   // saturating statistics; a clear wins over an increment in the same cycle
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (clr_stats) begin
         hit_count_d  = '0;
         miss_count_d = '0;
      end else if (rsp_fire) begin
         if (rsp_hit_q) begin
            if (hit_count_q != CNT_MAX) hit_count_d = hit_count_q + CNT_W'(1);
         end else begin
            if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_W'(1);
         end
      end
   end

   // statistics registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_hit       = rsp_hit_q;
   assign rsp_way       = rsp_way_q;
   assign rsp_multi_hit = rsp_multi_q;
   assign rsp_word      = rsp_word_q;
   assign hit_count     = hit_count_q;
   assign miss_count    = miss_count_q;

endmodule

// File: doc/cache_hit_select.md
Name: cache_hit_select

Overview:
- Parametrised, pipelined successor to the single-way tag compare / word-mux path in the cache datapath.
- Compares a request tag against all WAYS stored tags and gates each compare with its valid bit.
- Selects the hitting block, then extracts the addressed word. Registered valid/ready handshakes sit on both sides.
- Sits between the tag/data array read and the CPU-side response path; also keeps saturating hit and miss statistics.

Parameters:
TAG, 20, tag width in bits
WAYS, 4, associativity (power of two, 1..16)
DATA_BLOCK, 128, block width in bits
WORD_SIZE_BIT, 32, word width; DATA_BLOCK/WORD_SIZE_BIT is a power of two >= 2
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts request this cycle
req_tag  in  TAG  lookup tag
req_word  in  log2(DATA_BLOCK/WORD_SIZE_BIT)  word offset within block
way_tag  in  WAYS*TAG  stored tags, way i at [i*TAG +: TAG]
way_valid  in  WAYS  per-way valid bits
way_data  in  WAYS*DATA_BLOCK  stored blocks, way i at [i*DATA_BLOCK +: DATA_BLOCK]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hit  out  1  at least one valid way matched
rsp_way  out  max(1,log2 WAYS)  hitting way index; 0 on miss
rsp_multi_hit  out  1  more than one valid way matched (error flag)
rsp_word  out  WORD_SIZE_BIT  selected word; 0 on miss
clr_stats  in  1  synchronous clear of counters
hit_count  out  CNT_W  completed hit responses
miss_count  out  CNT_W  completed miss responses

Behaviour:
- Reset (async, active-high): s1_valid=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_multi_hit=0, rsp_word=0, hit_count=0, miss_count=0. In-flight requests are discarded. No response emerges after reset deasserts unless a new request is accepted.
- Request transfer occurs when req_valid && req_ready. way_tag, way_valid and way_data are sampled in the same cycle as req_tag.
- Stage 1 (on accept):
  - Compute match[i] = way_valid[i] && (way_tag[i]==req_tag).
  - Register: hit = |match; way = index of lowest set match bit; multi = more than one match bit set; block = way_data[way]; word offset.
- Stage 2: rsp_word = block[word*WORD_SIZE_BIT +: WORD_SIZE_BIT] when hit, else 0. All rsp_* outputs are registered.
- Latency: accepted in cycle N gives rsp_valid in cycle N+2 when unstalled. Throughput is 1 request/cycle.
- Flow control:
  - adv2 = !rsp_valid || rsp_ready.
  - adv1 = !s1_valid || adv2.
  - req_ready = adv1. This is combinational from rsp_ready, with no path from req_valid.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and no data is lost. Two requests may be buffered (s1 and output).
- Multi-hit: lowest index wins, rsp_hit=1, rsp_multi_hit=1.
- Miss: rsp_hit=0, rsp_way=0, rsp_multi_hit=0, rsp_word=0.
- Invalid ways never match, even on equal tags.
- WAYS=1: rsp_way is 1 bit, always 0.
- Counters:
  - On rsp_valid && rsp_ready, hit_count increments if rsp_hit, else miss_count increments.
  - Multi-hit counts as a hit.
  - Counters saturate at all-ones and do not wrap.
  - clr_stats zeroes both counters next edge and takes priority over a same-cycle increment; that response is not counted.

Test Plan:
- Single hit: WAYS=4, way_tag={0x0AAAA,0x12345,0x0BBBB,0x0CCCC} (way0 first), way_valid=4'b1111, way1 data word2=0xDEADBEEF, req_tag=0x12345, req_word=2, rsp_ready=1 -> two cycles later rsp_valid=1, rsp_hit=1, rsp_way=1, rsp_multi_hit=0, rsp_word=0xDEADBEEF; hit_count=1.
- Miss and invalid: req_tag=0x12345 with way_valid[1]=0 and no other match -> rsp_hit=0, rsp_way=0, rsp_word=0; miss_count=1.
- Multi-hit: ways 2 and 3 hold tag 0x00077, both valid -> rsp_way=2, rsp_multi_hit=1, word taken from way 2.
- Backpressure: issue 4 back-to-back requests with rsp_ready=0 -> req_ready drops after 2 accepted, rsp_* holds the first response stable. Raise rsp_ready -> all 4 responses arrive in order, none lost or duplicated.
- Saturation/clear:
  - Force CNT_W=4 and run 17 hits -> hit_count stays 15.
  - Assert clr_stats in the same cycle as a completing hit -> hit_count=0 next cycle.
- Reset mid-flight: assert reset with s1 and output stages full -> rsp_valid=0 and counters=0 immediately (asynchronously). After release, no stale response appears.
